// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: default field widths, the stage record layout
// and the all-zero bubble record.
package cpu_pipe_pkg;

   localparam int unsigned DATA_W_DEF = 96;
   localparam int unsigned TNEW_W_DEF = 2;
   localparam int unsigned REG_W_DEF  = 5;
   localparam int unsigned DEPTH_MAX  = 4;

   // Stage record at default widths; parametrised modules keep the same field order.
   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic [REG_W_DEF-1:0]  write_reg;
      logic [TNEW_W_DEF-1:0] tnew;
      logic [DATA_W_DEF-1:0] data;
   } stage_t;

   localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: load / hold / clear with saturating Tnew decrement.
// A source with valid=0 is captured as a full bubble, so an empty stage never
// carries RegWrite or a nonzero Tnew.
module pipe_stage_cell
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned TNEW_W = TNEW_W_DEF,
   parameter int unsigned REG_W  = REG_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              stall,
   input  logic              src_valid,
   input  logic              src_reg_write,
   input  logic [REG_W-1:0]  src_write_reg,
   input  logic [TNEW_W-1:0] src_tnew,
   input  logic [DATA_W-1:0] src_data,
   output logic              valid,
   output logic              reg_write,
   output logic [REG_W-1:0]  write_reg,
   output logic [TNEW_W-1:0] tnew,
   output logic [DATA_W-1:0] data
);

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic [REG_W-1:0]  write_reg;
      logic [TNEW_W-1:0] tnew;
      logic [DATA_W-1:0] data;
   } rec_t;

   rec_t q;
   rec_t nxt;

   // Next record: a real source with Tnew counted down (saturating), else a bubble.
   always_comb begin
      nxt = '0;
      if (src_valid) begin
         nxt.valid     = 1'b1;
         nxt.reg_write = src_reg_write;
         nxt.write_reg = src_write_reg;
         nxt.tnew      = (src_tnew == '0) ? '0 : src_tnew - TNEW_W'(1);
         nxt.data      = src_data;
      end
   end

   // Stage register: flush beats stall, stall holds everything including Tnew.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (!stall) begin
         q <= nxt;
      end
   end

   assign valid     = q.valid;
   assign reg_write = q.reg_write;
   assign write_reg = q.write_reg;
   assign tnew      = q.tnew;
   assign data      = q.data;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH back-to-back pipeline stages with stall, flush and explicit valid.
// Optional in-flight RAW hazard checker enabled by PIPE_STAGE_CHAIN_HAZARD_EN;
// without it Stall_Req is tied low and the Rs/Rt/Tuse inputs are ignored.
module pipe_stage_chain
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 1,
   parameter int unsigned TNEW_W = TNEW_W_DEF,
   parameter int unsigned REG_W  = REG_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              In_Valid,
   input  logic [DATA_W-1:0] Data_In,
   input  logic [REG_W-1:0]  WriteReg_In,
   input  logic              RegWrite_In,
   input  logic [TNEW_W-1:0] Tnew_In,
   output logic              Out_Valid,
   output logic [DATA_W-1:0] Data_Out,
   output logic [REG_W-1:0]  WriteReg_Out,
   output logic              RegWrite_Out,
   output logic [TNEW_W-1:0] Tnew_Out,
   input  logic [REG_W-1:0]  Rs_Addr,
   input  logic [REG_W-1:0]  Rt_Addr,
   input  logic [TNEW_W-1:0] Tuse_Rs,
   input  logic [TNEW_W-1:0] Tuse_Rt,
   output logic              Stall_Req
);

   if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_depth_check
      $error("pipe_stage_chain: DEPTH must be in 1..4");
   end

   logic [DEPTH-1:0]             valid_s;
   logic [DEPTH-1:0]             reg_write_s;
   logic [DEPTH-1:0][REG_W-1:0]  write_reg_s;
   logic [DEPTH-1:0][TNEW_W-1:0] tnew_s;
   logic [DEPTH-1:0][DATA_W-1:0] data_s;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic              src_valid;
      logic              src_reg_write;
      logic [REG_W-1:0]  src_write_reg;
      logic [TNEW_W-1:0] src_tnew;
      logic [DATA_W-1:0] src_data;

      if (g == 0) begin : g_head
         assign src_valid     = In_Valid;
         assign src_reg_write = RegWrite_In;
         assign src_write_reg = WriteReg_In;
         assign src_tnew      = Tnew_In;
         assign src_data      = Data_In;
      end else begin : g_link
         assign src_valid     = valid_s[g-1];
         assign src_reg_write = reg_write_s[g-1];
         assign src_write_reg = write_reg_s[g-1];
         assign src_tnew      = tnew_s[g-1];
         assign src_data      = data_s[g-1];
      end

      pipe_stage_cell #(
         .DATA_W (DATA_W),
         .TNEW_W (TNEW_W),
         .REG_W  (REG_W)
      ) u_cell (
         .clk           (Clk),
         .rst_n         (Reset_n),
         .flush         (Flush),
         .stall         (Stall),
         .src_valid     (src_valid),
         .src_reg_write (src_reg_write),
         .src_write_reg (src_write_reg),
         .src_tnew      (src_tnew),
         .src_data      (src_data),
         .valid         (valid_s[g]),
         .reg_write     (reg_write_s[g]),
         .write_reg     (write_reg_s[g]),
         .tnew          (tnew_s[g]),
         .data          (data_s[g])
      );
   end

   assign Out_Valid    = valid_s[DEPTH-1];
   assign Data_Out     = data_s[DEPTH-1];
   assign WriteReg_Out = write_reg_s[DEPTH-1];
   assign RegWrite_Out = reg_write_s[DEPTH-1] & valid_s[DEPTH-1];
   assign Tnew_Out     = tnew_s[DEPTH-1];

`ifdef PIPE_STAGE_CHAIN_HAZARD_EN
   // Hazard: any in-flight writer of a source register whose result is later than needed.
   always_comb begin
      Stall_Req = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_s[i] && reg_write_s[i] && (write_reg_s[i] != '0)) begin
            if ((write_reg_s[i] == Rs_Addr) && (tnew_s[i] > Tuse_Rs)) begin
               Stall_Req = 1'b1;
            end
            if ((write_reg_s[i] == Rt_Addr) && (tnew_s[i] > Tuse_Rt)) begin
               Stall_Req = 1'b1;
            end
         end
      end
   end
`else
   logic unused_hazard_inputs;
   assign unused_hazard_inputs = ^{Rs_Addr, Rt_Addr, Tuse_Rs, Tuse_Rt};
   assign Stall_Req = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: a DEPTH=2 and a DEPTH=1 instance
// share one stimulus stream and are compared every cycle against an
// entry/age model, plus directed literal checks.
module tb_pipe_stage_chain;

`ifdef PIPE_STAGE_CHAIN_HAZARD_EN
   localparam bit HZ_EN = 1'b1;
`else
   localparam bit HZ_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Stall = 1'b0;
   logic        Flush = 1'b0;
   logic        In_Valid = 1'b0;
   logic [95:0] Data_In = '0;
   logic [4:0]  WriteReg_In = '0;
   logic        RegWrite_In = 1'b0;
   logic [1:0]  Tnew_In = '0;
   logic [4:0]  Rs_Addr = '0;
   logic [4:0]  Rt_Addr = '0;
   logic [1:0]  Tuse_Rs = '0;
   logic [1:0]  Tuse_Rt = '0;

   logic        o2_valid, o2_rw, sr2;
   logic [95:0] o2_data;
   logic [4:0]  o2_wr;
   logic [1:0]  o2_tnew;
   logic        o1_valid, o1_rw, sr1;
   logic [95:0] o1_data;
   logic [4:0]  o1_wr;
   logic [1:0]  o1_tnew;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   always #5 Clk = ~Clk;

   pipe_stage_chain #(.DATA_W(96), .DEPTH(2), .TNEW_W(2), .REG_W(5)) u_d2 (
      .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush),
      .In_Valid(In_Valid), .Data_In(Data_In), .WriteReg_In(WriteReg_In),
      .RegWrite_In(RegWrite_In), .Tnew_In(Tnew_In),
      .Out_Valid(o2_valid), .Data_Out(o2_data), .WriteReg_Out(o2_wr),
      .RegWrite_Out(o2_rw), .Tnew_Out(o2_tnew),
      .Rs_Addr(Rs_Addr), .Rt_Addr(Rt_Addr), .Tuse_Rs(Tuse_Rs), .Tuse_Rt(Tuse_Rt),
      .Stall_Req(sr2));

   pipe_stage_chain #(.DATA_W(96), .DEPTH(1), .TNEW_W(2), .REG_W(5)) u_d1 (
      .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush),
      .In_Valid(In_Valid), .Data_In(Data_In), .WriteReg_In(WriteReg_In),
      .RegWrite_In(RegWrite_In), .Tnew_In(Tnew_In),
      .Out_Valid(o1_valid), .Data_Out(o1_data), .WriteReg_Out(o1_wr),
      .RegWrite_Out(o1_rw), .Tnew_Out(o1_tnew),
      .Rs_Addr(Rs_Addr), .Rt_Addr(Rt_Addr), .Tuse_Rs(Tuse_Rs), .Tuse_Rt(Tuse_Rt),
      .Stall_Req(sr1));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each slot remembers the instruction as it entered and how many
   // captures it has seen; Tnew is derived from that age.
   typedef struct {
      bit          v;
      bit          rw;
      int unsigned wr;
      int unsigned tin;
      int unsigned adv;
      bit [95:0]   d;
   } ent_t;

   ent_t m2[2];
   ent_t m1;
   ent_t empty_ent;

   function automatic int unsigned age_tnew(input ent_t e);
      return (e.tin > e.adv) ? e.tin - e.adv : 0;
   endfunction

   function automatic bit hz(input ent_t e);
      int unsigned t;
      t = age_tnew(e);
      if (!e.v || !e.rw || e.wr == 0) return 1'b0;
      return ((e.wr == Rs_Addr) && (t > Tuse_Rs)) || ((e.wr == Rt_Addr) && (t > Tuse_Rt));
   endfunction

   always @(posedge Clk or negedge Reset_n) begin
      ent_t n;
      if (!Reset_n || Flush) begin
         m2[0] = empty_ent;
         m2[1] = empty_ent;
         m1    = empty_ent;
      end else if (!Stall) begin
         n = empty_ent;
         if (In_Valid) begin
            n.v = 1'b1; n.rw = RegWrite_In; n.wr = WriteReg_In;
            n.tin = Tnew_In; n.adv = 1; n.d = Data_In;
         end
         m2[1] = m2[0];
         if (m2[1].v) m2[1].adv++;
         m2[0] = n;
         m1    = n;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      chk("d2_valid", o2_valid, m2[1].v);
      chk("d2_data",  o2_data,  m2[1].d);
      chk("d2_wr",    o2_wr,    m2[1].wr);
      chk("d2_rw",    o2_rw,    m2[1].v & m2[1].rw);
      chk("d2_tnew",  o2_tnew,  age_tnew(m2[1]));
      chk("d2_sreq",  sr2,      HZ_EN & (hz(m2[0]) | hz(m2[1])));
      chk("d1_valid", o1_valid, m1.v);
      chk("d1_data",  o1_data,  m1.d);
      chk("d1_wr",    o1_wr,    m1.wr);
      chk("d1_rw",    o1_rw,    m1.v & m1.rw);
      chk("d1_tnew",  o1_tnew,  age_tnew(m1));
      chk("d1_sreq",  sr1,      HZ_EN & hz(m1));
   end

   task automatic step();
      @(posedge Clk);
      #2;
   endtask

   task automatic inject(input logic [95:0] d, input logic [4:0] wr, input logic rw, input logic [1:0] tn);
      In_Valid = 1'b1; Data_In = d; WriteReg_In = wr; RegWrite_In = rw; Tnew_In = tn;
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      chk("rst_valid", o2_valid, 0);
      chk("rst_data",  o2_data,  0);
      chk("rst_tnew1", o1_tnew,  0);
      Reset_n = 1'b1;

      // Latency with DEPTH=2
      inject(96'h1234, 5'd8, 1'b1, 2'd2);
      step();
      In_Valid = 1'b0;
      chk("lat_pre_valid", o2_valid, 0);
      chk("lat_pre_data",  o2_data,  0);
      chk("lat_d1_valid",  o1_valid, 1);
      chk("lat_d1_tnew",   o1_tnew,  1);
      step();
      chk("lat_valid", o2_valid, 1);
      chk("lat_data",  o2_data,  96'h1234);
      chk("lat_wr",    o2_wr,    8);
      chk("lat_rw",    o2_rw,    1);
      chk("lat_tnew",  o2_tnew,  0);

      // Tnew saturation with DEPTH=1
      inject(96'h55, 5'd3, 1'b1, 2'd0);
      step();
      chk("sat_zero", o1_tnew, 0);
      inject(96'h66, 5'd3, 1'b1, 2'd3);
      step();
      chk("sat_three", o1_tnew, 2);
      In_Valid = 1'b0;

      // Stall hold
      Flush = 1'b1; step(); Flush = 1'b0;
      inject(96'hBEEF, 5'd9, 1'b1, 2'd3);
      step();
      In_Valid = 1'b0;
      Stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_d2_valid", o2_valid, 0);
         chk("stall_d1_tnew",  o1_tnew,  2);
         chk("stall_d1_data",  o1_data,  96'hBEEF);
      end
      Stall = 1'b0;
      step();
      chk("stall_rel_valid", o2_valid, 1);
      chk("stall_rel_data",  o2_data,  96'hBEEF);
      chk("stall_rel_tnew",  o2_tnew,  1);

      // Flush beats stall, input dropped
      Stall = 1'b1; Flush = 1'b1;
      inject(96'hDEAD, 5'd7, 1'b1, 2'd1);
      step();
      chk("flush_d2_valid", o2_valid, 0);
      chk("flush_d1_valid", o1_valid, 0);
      Stall = 1'b0; Flush = 1'b0; In_Valid = 1'b0;
      step();
      chk("flush_dropped", o2_valid, 0);

      // Hazard checker
      Flush = 1'b1; step(); Flush = 1'b0;
      inject(96'h1, 5'd8, 1'b1, 2'd2);
      step();
      In_Valid = 1'b0; Stall = 1'b1;
      Rs_Addr = 5'd8; Tuse_Rs = 2'd0; #1;
      chk("hz_hit_d2", sr2, HZ_EN);
      chk("hz_hit_d1", sr1, HZ_EN);
      Tuse_Rs = 2'd1; #1;
      chk("hz_tuse_ok", sr2, 0);
      Stall = 1'b0; Flush = 1'b1; step(); Flush = 1'b0;
      inject(96'h2, 5'd0, 1'b1, 2'd2);
      step();
      In_Valid = 1'b0; Stall = 1'b1;
      Rs_Addr = 5'd0; Tuse_Rs = 2'd0; #1;
      chk("hz_reg0", sr1, 0);
      Stall = 1'b0; Rs_Addr = '0;

      // Async reset while full
      for (int k = 0; k < 3; k++) begin
         inject(96'hA0 + 96'(k), 5'd4, 1'b1, 2'd3);
         step();
      end
      In_Valid = 1'b0;
      Reset_n = 1'b0; #1;
      chk("areset_d2_valid", o2_valid, 0);
      chk("areset_d2_data",  o2_data,  0);
      chk("areset_d1_valid", o1_valid, 0);
      step();
      Reset_n = 1'b1;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int unsigned sel;
         Stall    = ($urandom_range(0, 99) < 20);
         Flush    = ($urandom_range(0, 99) < 5);
         In_Valid = ($urandom_range(0, 99) < 70);
         Data_In  = {$urandom, $urandom, $urandom};
         sel = $urandom_range(0, 3);
         WriteReg_In = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd8 : (sel == 2) ? 5'd9 : 5'($urandom);
         RegWrite_In = $urandom_range(0, 1);
         Tnew_In  = 2'($urandom);
         Rs_Addr  = ($urandom_range(0, 1) == 1) ? 5'd8 : 5'($urandom);
         Rt_Addr  = ($urandom_range(0, 1) == 1) ? 5'd9 : 5'($urandom);
         Tuse_Rs  = 2'($urandom);
         Tuse_Rt  = 2'($urandom);
         Reset_n  = 1'b1;
         if ($urandom_range(0, 199) == 0) begin
            Reset_n = 1'b0; #1;
            chk("rnd_areset_valid", o2_valid, 0);
         end
         step();
      end
      Reset_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
